// File: rtl/yolo_acc_dbg_pkg.sv
// Shared types and defaults for the yolo_acc_top deadlock watchdog.
// Holds the FSM state enum and the lowest-set-bit helper.
package yolo_acc_dbg_pkg;

    localparam int NUM_MON = 4;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        WATCH,
        SUSPECT,
        REPORT,
        HALT
    } wd_state_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int lowest_set(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/yolo_acc_deadlock_prio_enc.sv
// Lowest-set-bit encoder over the monitor block vector.
// Purely combinational; found flags that any bit is set.
module yolo_acc_deadlock_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    import yolo_acc_dbg_pkg::*;

    logic [31:0] wide;

    always_comb begin
        wide        = '0;
        wide[N-1:0] = vec;
        idx         = IDX_W'(lowest_set(wide));
        found       = |vec;
    end

endmodule

// File: rtl/yolo_acc_top_deadlock_watchdog.sv
// Deadlock watchdog: picks one blocked monitor, confirms persistence,
// reports it once over valid/ready and then holds a sticky flag.
module yolo_acc_top_deadlock_watchdog #(
    parameter int NUM_MON = yolo_acc_dbg_pkg::NUM_MON,
    parameter int CNT_W   = yolo_acc_dbg_pkg::CNT_W,
    parameter int IDX_W   = 2
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               enable,
    input  logic               clear,
    input  logic [CNT_W-1:0]   cfg_thresh,
    input  logic [NUM_MON-1:0] block_in,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [IDX_W-1:0]   rpt_idx,
    output logic [CNT_W-1:0]   rpt_cycles,
    output logic               deadlock,
    output logic               busy
);
    import yolo_acc_dbg_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wd_state_e        state;
    wd_state_e        state_nxt;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_found;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] cnt;
    logic             cand_blk;
    logic             hit;
    logic             hs;

    yolo_acc_deadlock_prio_enc #(
        .N     (NUM_MON),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec   (block_in),
        .idx   (enc_idx),
        .found (enc_found)
    );

    assign cand_blk = block_in[cand];
    assign hit      = (cnt == thr);
    assign hs       = rpt_valid & rpt_ready;

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = enable ? WATCH : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) state_nxt = WATCH;
                end
                WATCH: begin
                    if (!enable)        state_nxt = IDLE;
                    else if (enc_found) state_nxt = SUSPECT;
                end
                SUSPECT: begin
                    // Reaching the threshold wins over a same-cycle drop.
                    if (!enable)       state_nxt = IDLE;
                    else if (hit)      state_nxt = REPORT;
                    else if (!cand_blk) state_nxt = WATCH;
                end
                REPORT: begin
                    if (hs) state_nxt = HALT;
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            thr        <= '0;
            cand       <= '0;
            rpt_valid  <= 1'b0;
            rpt_idx    <= '0;
            rpt_cycles <= '0;
            deadlock   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SUSPECT) || (state_nxt == REPORT);
            if (clear) begin
                cnt       <= '0;
                rpt_valid <= 1'b0;
                deadlock  <= 1'b0;
            end else begin
                unique case (state)
                    WATCH: begin
                        if (enable && enc_found) begin
                            cand <= enc_idx;
                            thr  <= (cfg_thresh == '0) ? CNT_ONE : cfg_thresh;
                            cnt  <= CNT_ONE;
                        end
                    end
                    SUSPECT: begin
                        if (!enable) begin
                            cnt <= '0;
                        end else if (hit) begin
                            rpt_idx    <= cand;
                            rpt_cycles <= cnt;
                            rpt_valid  <= 1'b1;
                        end else if (cand_blk) begin
                            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    REPORT: begin
                        if (hs) begin
                            rpt_valid <= 1'b0;
                            deadlock  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_yolo_acc_top_deadlock_watchdog.sv
// Bench for the deadlock watchdog: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the watchdog rules.
module tb_yolo_acc_top_deadlock_watchdog;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        enable;
    logic        clear;
    logic [15:0] cfg_thresh;
    logic [3:0]  block_in;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [1:0]  rpt_idx;
    logic [15:0] rpt_cycles;
    logic        deadlock;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ap_clk = ~ap_clk;

    yolo_acc_top_deadlock_watchdog dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .enable     (enable),
        .clear      (clear),
        .cfg_thresh (cfg_thresh),
        .block_in   (block_in),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_idx    (rpt_idx),
        .rpt_cycles (rpt_cycles),
        .deadlock   (deadlock),
        .busy       (busy)
    );

    // Model: armed watching, current suspect (-1 = none), its run length,
    // a pending report and the halted flag.
    bit m_on;
    bit m_pend;
    bit m_halt;
    int m_susp;
    int m_run;
    int m_lim;
    int m_ridx;
    int m_rcyc;

    function automatic int lowest(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        if (!ap_rst_n) begin
            m_on = 0; m_pend = 0; m_halt = 0; m_susp = -1;
            m_run = 0; m_ridx = 0; m_rcyc = 0;
        end else if (clear) begin
            m_pend = 0; m_halt = 0; m_susp = -1; m_on = enable;
        end else if (m_pend) begin
            if (rpt_ready) begin
                m_pend = 0;
                m_halt = 1;
            end
        end else if (m_halt) begin
        end else if (!m_on) begin
            if (enable) m_on = 1;
        end else if (!enable) begin
            m_on = 0; m_susp = -1;
        end else if (m_susp < 0) begin
            if (block_in != 0) begin
                m_susp = lowest(block_in);
                m_lim  = (cfg_thresh == 0) ? 1 : int'(cfg_thresh);
                m_run  = 1;
            end
        end else if (m_run == m_lim) begin
            m_pend = 1; m_ridx = m_susp; m_rcyc = m_run; m_susp = -1;
        end else if (block_in[m_susp]) begin
            m_run = (m_run < 65535) ? m_run + 1 : 65535;
        end else begin
            m_susp = -1;
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        model_step();
        #1;
        check("rpt_valid", rpt_valid, m_pend);
        check("rpt_idx", rpt_idx, m_ridx);
        check("rpt_cycles", rpt_cycles, m_rcyc);
        check("deadlock", deadlock, m_halt);
        check("busy", busy, (m_susp >= 0) || m_pend);
    endtask

    task automatic drive(input bit en, input bit clr, input logic [15:0] th,
                         input logic [3:0] blk, input bit rdy);
        enable = en; clear = clr; cfg_thresh = th;
        block_in = blk; rpt_ready = rdy;
        step();
    endtask

    int lat;

    initial begin
        ap_rst_n = 1'b0;
        m_susp = -1;
        // Reset holds everything low despite blocked monitors
        repeat (3) drive(1, 0, 16'd8, 4'b1111, 1);
        ap_rst_n = 1'b1;
        drive(1, 0, 16'd8, 4'b0000, 0);

        // Threshold 8 on monitor 2, report then handshake
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 16'd8, 4'b0100, 0);
            lat++;
            if (rpt_valid) break;
        end
        check("lat_thr8", lat, 9);
        check("idx_thr8", rpt_idx, 2);
        check("cyc_thr8", rpt_cycles, 8);
        drive(1, 0, 16'd8, 4'b0100, 1);
        check("halt_flag", deadlock, 1);
        repeat (3) drive(1, 0, 16'd8, 4'b1111, 0);
        drive(1, 1, 16'd8, 4'b0000, 0);

        // Short block then drop, then a full-length block
        repeat (5) drive(1, 0, 16'd8, 4'b0010, 0);
        repeat (2) drive(1, 0, 16'd8, 4'b0000, 0);
        check("busy_drop", busy, 0);
        repeat (12) drive(1, 0, 16'd8, 4'b0010, 1);
        drive(1, 1, 16'd8, 4'b0000, 0);

        // Simultaneous blocks, then the suspect drops
        repeat (2) drive(1, 0, 16'd3, 4'b1010, 0);
        repeat (8) drive(1, 0, 16'd3, 4'b1000, 0);
        check("idx_switch", rpt_idx, 3);
        drive(1, 1, 16'd3, 4'b0000, 0);
        repeat (6) drive(1, 0, 16'd3, 4'b1010, 0);
        check("idx_lowest", rpt_idx, 1);

        // Stalled report, then clear beats handshake
        repeat (10) drive(1, 0, 16'd3, 4'b0000, 0);
        drive(1, 1, 16'd3, 4'b0000, 1);
        check("clr_no_dl", deadlock, 0);
        drive(1, 0, 16'd3, 4'b0000, 0);

        // Threshold 0 behaves as 1
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 16'd0, 4'b0001, 0);
            lat++;
            if (rpt_valid) break;
        end
        check("lat_thr0", lat, 2);
        check("cyc_thr0", rpt_cycles, 1);
        drive(1, 1, 16'd0, 4'b0000, 0);

        // Huge threshold, enable dropped mid-suspect
        repeat (10) drive(1, 0, 16'hFFFF, 4'b0001, 0);
        drive(0, 0, 16'hFFFF, 4'b0001, 0);
        repeat (3) drive(0, 0, 16'hFFFF, 4'b0001, 0);
        check("en_off_busy", busy, 0);
        drive(1, 0, 16'd2, 4'b0000, 0);

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            logic [3:0] b;
            b = block_in;
            if ($urandom_range(0, 3) == 0) b = 4'($urandom);
            ap_rst_n = ($urandom_range(0, 400) != 0);
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 40) == 0,
                  16'($urandom_range(0, 6)), b, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
